mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Memory-side responder for the byte-serial bus driven by the core's memory controller.
- Each cycle it accepts one byte access (address, write byte, read/write select) and decodes it to either the internal RAM array or the I/O window at IO_BASE.
- I/O window: UART-style TX/RX byte FIFOs and a halt register.
- Drives registered read data one cycle after the address is presented, plus back-pressure (io_buffer_full) to the controller.

Parameters:
RAM_ADDR_WIDTH, 17, byte-address width of the RAM (2^17 bytes); RAM uses mem_addr[RAM_ADDR_WIDTH-1:0].
TX_DEPTH, 16, TX FIFO depth in bytes (power of two).
RX_DEPTH, 16, RX FIFO depth in bytes (power of two).
FULL_MARGIN, 2, free TX slots at or below which io_buffer_full asserts.
IO_BASE, 32'h30000, base of the I/O window.

Ports:
clk_in  input  1  clock; all state updates on rising edge.
rst_n_in  input  1  reset; asynchronous, active-low.
rdy_in  input  1  global enable; when low, no state changes (RAM, FIFOs, mem_read, halt all hold).
mem_addr  input  32  byte address of the current access.
mem_write  input  8  write byte; ignored when r_nw_in=1.
r_nw_in  input  1  1 = read, 0 = write.
mem_read  output  8  read byte; registered, corresponds to the access presented in the previous rdy cycle.
io_buffer_full  output  1  registered; 1 when TX free slots <= FULL_MARGIN.
tx_data  output  8  TX FIFO head byte.
tx_valid  output  1  TX FIFO non-empty.
tx_ready  input  1  consumer pops the TX head when tx_valid && tx_ready.
rx_data  input  8  incoming byte.
rx_valid  input  1  pushes rx_data into the RX FIFO when rx_ready.
rx_ready  output  1  RX FIFO not full.
halt_out  output  1  sticky halt request.
tx_overflow_out  output  1  sticky; set when a TX write arrives while the TX FIFO is full.

Behaviour:
- Reset (rst_n_in=0, async):
  - mem_read=0, io_buffer_full=0, halt_out=0, tx_overflow_out=0.
  - Both FIFOs emptied (pointers and counts zeroed), so tx_valid=0 and rx_ready=1.
  - RAM contents are not cleared.
  - Reset mid-access discards the in-flight read; the first post-reset mem_read reflects the first post-reset access.
- Address decode (combinational, on each rdy cycle):
  - mem_addr == IO_BASE: DATA port.
  - mem_addr == IO_BASE+4: CTRL port.
  - mem_addr < IO_BASE: RAM.
  - Any other address: unmapped; writes ignored, reads return 8'h00.
- RAM:
  - Write: ram[addr] <= mem_write in the same cycle.
  - Read: mem_read <= ram[addr], giving 1-cycle latency.
  - Read of an address written in the previous cycle returns the new byte.
  - Same-cycle read and write cannot occur (single port).
- DATA write: push mem_write into TX. If TX is full, the byte is dropped and tx_overflow_out is set.
- DATA read:
  - RX non-empty: mem_read <= RX head and RX pops.
  - RX empty: mem_read <= 8'h00, no pop.
- CTRL write: any byte sets halt_out=1 (sticky until reset).
- CTRL read: mem_read <= {5'b0, halt_out, rx_nonempty, tx_full}.
- Controller idle traffic (reads of address 0) must cause no side effects. Only an exact DATA-address read pops RX.
- FIFOs:
  - Circular buffers with log2(DEPTH)+1-bit counts; pointers wrap at DEPTH.
  - Simultaneous push and pop on the same FIFO: both occur, count unchanged. This is legal when full (TX write + tx_ready pop) and when empty with a push (bypass not required; head visible the next cycle).
- io_buffer_full is registered from the next-state TX count: (TX_DEPTH - count_next) <= FULL_MARGIN.
  - FULL_MARGIN covers controller requests already issued before it samples io_buffer_full.
- tx_valid, tx_data and rx_ready are combinational from FIFO state.

Decomposition:
- Shared package: IO_BASE, CTRL offset (4), CTRL status bit positions, and the access-type encoding (r_nw: 1=read, 0=write), shared with the controller.
- One sub-module, byte_fifo (parameter DEPTH; push/pop/full/empty/count), instantiated twice for TX and RX.
- RAM array is inferred inline.

Test Plan:
- Write 8'hA5 to RAM 0x00100, then read 0x00100 -> mem_read=8'hA5 exactly one cycle after the read address is presented; reading 0x00101 (never written, preloaded 0) -> 8'h00.
- Write bytes 1..16 to 0x30000 with tx_ready=0 -> io_buffer_full=1 after the 14th byte, tx_overflow_out stays 0; a 17th write sets tx_overflow_out=1, tx_data=8'h01.
- With TX full, raise tx_ready while writing 8'h55 to 0x30000 in the same cycle -> count stays 16, tx_data advances to 8'h02, tx_overflow_out unchanged.
- Push rx 8'h41, 8'h42; read 0x30000 three times -> mem_read 8'h41, 8'h42, 8'h00; rx_ready stays 1. Idle reads of address 0 pop nothing.
- Write 8'h00 to 0x30004 -> halt_out=1 next cycle; read 0x30004 -> bit2=1. Drop rdy_in for 3 cycles during a RAM write -> no RAM change, mem_read held.
- Assert rst_n_in low mid-burst (TX count 5, halt=1) -> immediately tx_valid=0, halt_out=0, io_buffer_full=0, mem_read=0; RAM byte written earlier still reads back.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the byte-serial memory bus: I/O window map, CTRL status
// layout and the access-type encoding used by both controller and responder.
package mem_io_responder_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] IO_BASE     = 32'h0003_0000;
    localparam logic [ADDR_W-1:0] CTRL_OFFSET = 32'd4;

    localparam int unsigned CTRL_TX_FULL_BIT     = 0;
    localparam int unsigned CTRL_RX_NONEMPTY_BIT = 1;
    localparam int unsigned CTRL_HALT_BIT        = 2;

    typedef enum logic {
        ACC_WRITE = 1'b0,
        ACC_READ  = 1'b1
    } access_e;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_DATA,
        SEL_CTRL,
        SEL_NONE
    } sel_e;

    // Anything at or above IO_BASE that is not DATA/CTRL is unmapped.
    function automatic sel_e decode_addr(input logic [ADDR_W-1:0] addr);
        if (addr == IO_BASE)                    return SEL_DATA;
        else if (addr == IO_BASE + CTRL_OFFSET) return SEL_CTRL;
        else if (addr < IO_BASE)                return SEL_RAM;
        else                                    return SEL_NONE;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Controller-to-responder byte bus: one access per enabled cycle, registered read data back.
interface mem_io_responder_if;
    import mem_io_responder_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write;
    logic              r_nw_in;
    logic [DATA_W-1:0] mem_read;
    logic              io_buffer_full;

    modport master (
        output mem_addr, mem_write, r_nw_in,
        input  mem_read, io_buffer_full
    );

    modport slave (
        input  mem_addr, mem_write, r_nw_in,
        output mem_read, io_buffer_full
    );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Circular byte FIFO; the caller qualifies push/pop (no push when full unless popping,
// no pop when empty), so this block only tracks pointers and occupancy.
module mem_io_responder_byte_fifo #(
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout,
    output logic [CW-1:0]     o_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: decodes each byte access to RAM or the I/O window
// (TX/RX FIFOs, halt) and returns registered read data one cycle later.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH       = 16,
    parameter int unsigned RX_DEPTH       = 16,
    parameter int unsigned FULL_MARGIN    = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    mem_io_responder_if.slave bus,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              halt_out,
    output logic              tx_overflow_out
);

    localparam int unsigned TX_CW     = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CW     = $clog2(RX_DEPTH) + 1;
    localparam int unsigned RAM_BYTES = 1 << RAM_ADDR_WIDTH;

    sel_e                      w_sel;
    logic                      w_rd, w_wr;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_addr;
    logic [TX_CW-1:0]          w_tx_count, w_tx_count_next;
    logic [RX_CW-1:0]          w_rx_count;
    logic                      w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic                      w_tx_push_req, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic [DATA_W-1:0]         w_rx_dout, w_status, w_io_rdata;

    logic [DATA_W-1:0] r_ram [RAM_BYTES];
    logic [DATA_W-1:0] r_ram_q;
    logic [DATA_W-1:0] r_io_q;
    logic              r_ram_hit;
    logic              r_halt, r_tx_ovf, r_io_full;

    assign w_sel      = decode_addr(bus.mem_addr);
    assign w_rd       = rdy_in && (access_e'(bus.r_nw_in) == ACC_READ);
    assign w_wr       = rdy_in && (access_e'(bus.r_nw_in) == ACC_WRITE);
    assign w_ram_addr = bus.mem_addr[RAM_ADDR_WIDTH-1:0];

    assign w_tx_full  = (w_tx_count == TX_CW'(TX_DEPTH));
    assign w_tx_empty = (w_tx_count == '0);
    assign w_rx_full  = (w_rx_count == RX_CW'(RX_DEPTH));
    assign w_rx_empty = (w_rx_count == '0);

    // A full TX still accepts a write when the consumer pops in the same cycle.
    assign w_tx_pop        = rdy_in && tx_ready && !w_tx_empty;
    assign w_tx_push_req   = w_wr && (w_sel == SEL_DATA);
    assign w_tx_push       = w_tx_push_req && (!w_tx_full || w_tx_pop);
    assign w_tx_count_next = w_tx_count + TX_CW'(w_tx_push) - TX_CW'(w_tx_pop);

    assign w_rx_push = rdy_in && rx_valid && !w_rx_full;
    assign w_rx_pop  = w_rd && (w_sel == SEL_DATA) && !w_rx_empty;

    mem_io_responder_byte_fifo #(.DEPTH(TX_DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_din   (bus.mem_write),
        .o_dout  (tx_data),
        .o_count (w_tx_count)
    );

    mem_io_responder_byte_fifo #(.DEPTH(RX_DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_din   (rx_data),
        .o_dout  (w_rx_dout),
        .o_count (w_rx_count)
    );

    always_comb begin
        w_status                       = '0;
        w_status[CTRL_TX_FULL_BIT]     = w_tx_full;
        w_status[CTRL_RX_NONEMPTY_BIT] = !w_rx_empty;
        w_status[CTRL_HALT_BIT]        = r_halt;
    end

    // Read data for every non-RAM target; unmapped and empty-RX reads return zero.
    always_comb begin
        w_io_rdata = '0;
        if (w_rd) begin
            case (w_sel)
                SEL_DATA: if (!w_rx_empty) w_io_rdata = w_rx_dout;
                SEL_CTRL: w_io_rdata = w_status;
                default:  w_io_rdata = '0;
            endcase
        end
    end

    // Single-port RAM kept out of reset so it maps onto a memory macro.
    always_ff @(posedge clk_in) begin
        if (w_wr && (w_sel == SEL_RAM)) r_ram[w_ram_addr] <= bus.mem_write;
        if (w_rd && (w_sel == SEL_RAM)) r_ram_q <= r_ram[w_ram_addr];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ram_hit <= 1'b0;
            r_io_q    <= '0;
            r_halt    <= 1'b0;
            r_tx_ovf  <= 1'b0;
            r_io_full <= 1'b0;
        end else if (rdy_in) begin
            r_ram_hit <= w_rd && (w_sel == SEL_RAM);
            r_io_q    <= w_io_rdata;
            if (w_wr && (w_sel == SEL_CTRL)) r_halt   <= 1'b1;
            if (w_tx_push_req && !w_tx_push) r_tx_ovf <= 1'b1;
            r_io_full <= (TX_CW'(TX_DEPTH) - w_tx_count_next) <= TX_CW'(FULL_MARGIN);
        end
    end

    assign bus.mem_read       = r_ram_hit ? r_ram_q : r_io_q;
    assign bus.io_buffer_full = r_io_full;
    assign tx_valid           = !w_tx_empty;
    assign rx_ready           = !w_rx_full;
    assign halt_out           = r_halt;
    assign tx_overflow_out    = r_tx_ovf;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a behavioural model predicts every read byte
// into a scoreboard queue and checks it when the registered read data appears.
module tb_mem_io_responder;
    import mem_io_responder_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdy = 1'b1;
    logic       tx_ready = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid, rx_ready, halt, ovf;

    mem_io_responder_if bus();

    mem_io_responder #(
        .RAM_ADDR_WIDTH(17), .TX_DEPTH(16), .RX_DEPTH(16), .FULL_MARGIN(2)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .rdy_in          (rdy),
        .bus             (bus),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .halt_out        (halt),
        .tx_overflow_out (ovf)
    );

    always #5 clk = ~clk;

    logic [7:0] ram_m [int];
    logic [7:0] tx_m [$];
    logic [7:0] rx_m [$];
    bit         halt_m, ovf_m, iof_m;
    logic [7:0] sb_exp [$];
    string      sb_tag [$];
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    endtask

    task automatic drive(input logic rnw, input logic [31:0] a, input logic [7:0] d);
        bus.r_nw_in   = rnw;
        bus.mem_addr  = a;
        bus.mem_write = d;
    endtask

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic tick(input bit want, input string tag);
        logic [7:0]  exp_rd;
        logic [31:0] a;
        int          a17;
        bit          tx_pop, tx_push, rx_pop, rx_push;
        exp_rd = 8'h00;
        tx_pop = 0; tx_push = 0; rx_pop = 0; rx_push = 0;
        a   = bus.mem_addr;
        a17 = int'(a[16:0]);
        if (rdy) begin
            tx_pop  = tx_ready && (tx_m.size() != 0);
            rx_push = rx_valid && (rx_m.size() < 16);
            if (bus.r_nw_in) begin
                if (a == IO_BASE) begin
                    if (rx_m.size() != 0) begin exp_rd = rx_m[0]; rx_pop = 1; end
                end else if (a == IO_BASE + 32'd4) begin
                    exp_rd = {5'b0, halt_m, rx_m.size() != 0, tx_m.size() == 16};
                end else if (a < IO_BASE) begin
                    exp_rd = ram_m.exists(a17) ? ram_m[a17] : 8'h00;
                end
            end else begin
                if (a < IO_BASE) ram_m[a17] = bus.mem_write;
                else if (a == IO_BASE) begin
                    if (tx_m.size() < 16 || tx_pop) tx_push = 1;
                    else ovf_m = 1;
                end else if (a == IO_BASE + 32'd4) halt_m = 1;
            end
            if (tx_pop)  void'(tx_m.pop_front());
            if (tx_push) tx_m.push_back(bus.mem_write);
            if (rx_pop)  void'(rx_m.pop_front());
            if (rx_push) rx_m.push_back(rx_data);
            iof_m = (16 - tx_m.size()) <= 2;
            if (want) begin sb_exp.push_back(exp_rd); sb_tag.push_back(tag); end
        end
        @(posedge clk); #1;
        if (want && sb_exp.size() != 0) chk(sb_tag.pop_front(), bus.mem_read, sb_exp.pop_front());
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        drive(1'b0, a, d);
        tick(0, "");
        drive(1'b1, 32'h0, 8'h00);
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        drive(1'b1, a, 8'h00);
        tick(1, tag);
        drive(1'b1, 32'h0, 8'h00);
    endtask

    task automatic chk_outs(input string tag);
        chk($sformatf("%s.tx_valid", tag), 8'(tx_valid), 8'(tx_m.size() != 0));
        if (tx_m.size() != 0) chk($sformatf("%s.tx_data", tag), tx_data, tx_m[0]);
        chk($sformatf("%s.rx_ready", tag), 8'(rx_ready), 8'(rx_m.size() < 16));
        chk($sformatf("%s.io_full", tag), 8'(bus.io_buffer_full), 8'(iof_m));
        chk($sformatf("%s.halt", tag), 8'(halt), 8'(halt_m));
        chk($sformatf("%s.ovf", tag), 8'(ovf), 8'(ovf_m));
    endtask

    task automatic model_reset();
        tx_m.delete(); rx_m.delete(); sb_exp.delete(); sb_tag.delete();
        halt_m = 0; ovf_m = 0; iof_m = 0;
    endtask

    initial begin
        drive(1'b1, 32'h0, 8'h00);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.mem_read", bus.mem_read, 8'h00);
        chk_outs("reset");
        rst_n = 1'b1;

        // RAM: read-after-write, never-written byte, unmapped accesses
        wr(32'h00101, 8'h00);
        wr(32'h00100, 8'hA5);
        rd(32'h00100, "ram_rd_a5");
        rd(32'h00101, "ram_rd_zero");
        wr(32'h10008, 8'h11);
        wr(32'h30008, 8'h77);
        rd(32'h10008, "unmapped_wr_no_alias");
        rd(32'h30008, "unmapped_rd");

        // TX fill with consumer stalled
        for (int i = 1; i <= 16; i++) begin
            wr(IO_BASE, 8'(i));
            chk_outs($sformatf("tx_fill%0d", i));
        end
        wr(IO_BASE, 8'd17);
        chk_outs("tx_overflow");
        rd(IO_BASE + 32'd4, "ctrl_tx_full");

        // Full TX: simultaneous pop and push
        tx_ready = 1'b1;
        wr(IO_BASE, 8'h55);
        tx_ready = 1'b0;
        chk_outs("tx_full_push_pop");
        rd(IO_BASE + 32'd4, "ctrl_still_full");

        tx_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick(0, "");
            chk_outs($sformatf("drain%0d", i));
        end
        tx_ready = 1'b0;

        // RX pushes, idle traffic, DATA reads
        rx_valid = 1'b1; rx_data = 8'h41; tick(0, "");
        rx_data = 8'h42; tick(0, "");
        rx_valid = 1'b0;
        repeat (3) tick(0, "");
        rd(IO_BASE + 32'd4, "ctrl_rx_nonempty");
        rd(IO_BASE, "rx_pop_41");
        chk_outs("rx_after_pop1");
        rd(IO_BASE, "rx_pop_42");
        rd(IO_BASE, "rx_empty_read");
        chk_outs("rx_drained");

        // Halt
        wr(IO_BASE + 32'd4, 8'h00);
        chk_outs("halt_set");
        rd(IO_BASE + 32'd4, "ctrl_halt");

        // rdy_in low during a RAM write
        rd(32'h00100, "ram_before_stall");
        rdy = 1'b0;
        drive(1'b0, 32'h00100, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            tick(0, "");
            chk($sformatf("stall%0d.mem_read", i), bus.mem_read, 8'hA5);
        end
        rdy = 1'b1;
        drive(1'b1, 32'h0, 8'h00);
        rd(32'h00100, "ram_after_stall");

        // Async reset mid-burst
        for (int i = 0; i < 5; i++) wr(IO_BASE, 8'(8'h60 + i));
        chk_outs("pre_reset_burst");
        rd(32'h00100, "ram_in_flight");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.mem_read", bus.mem_read, 8'h00);
        chk_outs("async_rst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(32'h00100, "ram_kept_after_reset");
        rd(IO_BASE + 32'd4, "ctrl_after_reset");
        chk_outs("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
